// File: rtl/addsub_pkg.sv
// Shared encodings for the digit-serial add/subtract unit: op codes, FSM states
// and the digit-count helper.
package addsub_pkg;

    localparam logic ADDSUB_ADD = 1'b0;
    localparam logic ADDSUB_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Returns 0 when DIGIT does not divide WIDTH so the top can refuse to elaborate.
    function automatic int calc_ndig(input int width, input int digit);
        if (digit <= 0 || width <= 0 || (width % digit) != 0) begin
            return 0;
        end
        return width / digit;
    endfunction

endpackage

// File: rtl/digit_addsub.sv
// Combinational DIGIT-bit add/subtract slice. In subtract mode ci/co are a
// borrow-in/borrow-out chain rather than an inverted carry.
module digit_addsub
    import addsub_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic             op,
    input  logic             ci,
    input  logic [DIGIT-1:0] da,
    input  logic [DIGIT-1:0] db,
    output logic [DIGIT-1:0] dx,
    output logic             co
);

    logic c;

    always_comb begin
        c  = ci;
        dx = '0;
        for (int i = 0; i < DIGIT; i++) begin
            dx[i] = da[i] ^ db[i] ^ c;
            if (op == ADDSUB_ADD) begin
                c = (da[i] & db[i]) | (c & (da[i] ^ db[i]));
            end else begin
                c = (~da[i] & db[i]) | (c & ~(da[i] ^ db[i]));
            end
        end
        co = c;
    end

endmodule

// File: rtl/nbit_serial_addsub.sv
// Digit-serial add/subtract, LSB digit first, with valid/ready on both sides.
// Define NBIT_ADDSUB_SAT_EN to saturate x on signed overflow.
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// RUN   | one digit per cycle through the slice, carry held in carry_q
// DONE  | out_valid=1, result held until out_ready
module nbit_serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);
    localparam int M = DIGIT - 1;

    generate
        if (NDIG == 0) begin : g_bad_cfg
            $error("DIGIT must divide WIDTH");
        end
    endgenerate

    state_e             state_q;
    logic [WIDTH-1:0]   a_q, b_q, x_q;
    logic               op_q, carry_q, cout_q, ovf_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               in_ready_q, out_valid_q;

    logic [DIGIT-1:0]   dx;
    logic               co;
    logic [WIDTH-1:0]   x_d, x_fin_d;
    logic               ovf_d;

    digit_addsub #(.DIGIT(DIGIT)) u_slice (
        .op (op_q),
        .ci (carry_q),
        .da (a_q[DIGIT-1:0]),
        .db (b_q[DIGIT-1:0]),
        .dx (dx),
        .co (co)
    );

    // On the last digit the slice sees the operand MSBs, so overflow is judged there.
    always_comb begin
        x_d = x_q;
        x_d[int'(cnt_q) * DIGIT +: DIGIT] = dx;
        if (op_q == ADDSUB_ADD) begin
            ovf_d = (a_q[M] == b_q[M]) && (dx[M] != a_q[M]);
        end else begin
            ovf_d = (a_q[M] != b_q[M]) && (dx[M] != a_q[M]);
        end
`ifdef NBIT_ADDSUB_SAT_EN
        x_fin_d = ovf_d ? {a_q[M], {(WIDTH-1){~a_q[M]}}} : x_d;
`else
        x_fin_d = x_d;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            x_q         <= '0;
            op_q        <= 1'b0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        op_q       <= op;
                        carry_q    <= cin;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    carry_q <= co;
                    if (cnt_q == LAST) begin
                        x_q         <= x_fin_d;
                        cout_q      <= co;
                        ovf_q       <= ovf_d;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        x_q   <= x_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign x         = x_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_nbit_serial_addsub.sv
// Bench for nbit_serial_addsub: instance 0 is WIDTH=32/DIGIT=8, instance 1 is
// WIDTH=32/DIGIT=32, both checked against a plain-arithmetic reference model.
module tb_nbit_serial_addsub;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst       [2];
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic         op        [2];
    logic         cin       [2];
    logic [W-1:0] a         [2];
    logic [W-1:0] b         [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [W-1:0] x         [2];
    logic         cout      [2];
    logic         ovf       [2];
    logic         busy      [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nbit_serial_addsub #(.WIDTH(W), .DIGIT(8)) u_d8 (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .op(op[0]), .cin(cin[0]), .a(a[0]), .b(b[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .x(x[0]), .cout(cout[0]), .ovf(ovf[0]), .busy(busy[0])
    );

    nbit_serial_addsub #(.WIDTH(W), .DIGIT(32)) u_d32 (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .op(op[1]), .cin(cin[1]), .a(a[1]), .b(b[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .x(x[1]), .cout(cout[1]), .ovf(ovf[1]), .busy(busy[1])
    );

    function automatic int ndig_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic void ref_model(input logic o, input logic ci,
                                      input logic [W-1:0] ra, input logic [W-1:0] rb,
                                      output logic [W-1:0] rx, output logic rc,
                                      output logic rv);
        logic [W:0] s;
        if (o == 1'b0) begin
            s  = {1'b0, ra} + {1'b0, rb} + (W+1)'(ci);
            rx = s[W-1:0];
            rc = s[W];
            rv = (ra[W-1] == rb[W-1]) && (rx[W-1] != ra[W-1]);
        end else begin
            rx = ra - rb - W'(ci);
            rc = ({1'b0, ra} < ({1'b0, rb} + (W+1)'(ci)));
            rv = (ra[W-1] != rb[W-1]) && (rx[W-1] != ra[W-1]);
        end
`ifdef NBIT_ADDSUB_SAT_EN
        if (rv) rx = ra[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    endfunction

    task automatic run_op(input int k, input logic o, input logic ci,
                          input logic [W-1:0] ra, input logic [W-1:0] rb,
                          input logic pre_ready, input string tag);
        logic [W-1:0] ex;
        logic         ec, ev;
        int           n;
        ref_model(o, ci, ra, rb, ex, ec, ev);
        @(negedge clk);
        out_ready[k] = pre_ready;
        n = 0;
        while (in_ready[k] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s/%0d in_ready got %b want 1", tag, k, in_ready[k]);
        end
        in_valid[k] = 1'b1; op[k] = o; cin[k] = ci; a[k] = ra; b[k] = rb;
        @(negedge clk);
        in_valid[k] = 1'b0;
        n = 0;
        while (out_valid[k] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != ndig_of(k)) begin
            errors++;
            $display("FAIL %s/%0d latency got %0d want %0d", tag, k, n, ndig_of(k));
        end
        checks++;
        if (x[k] !== ex || cout[k] !== ec || ovf[k] !== ev) begin
            errors++;
            $display("FAIL %s/%0d result got x=%h cout=%b ovf=%b want x=%h cout=%b ovf=%b",
                     tag, k, x[k], cout[k], ovf[k], ex, ec, ev);
        end
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
        checks++;
        if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s/%0d release got out_valid=%b in_ready=%b busy=%b want 0 1 0",
                     tag, k, out_valid[k], in_ready[k], busy[k]);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; in_valid[k] = 1'b0; op[k] = 1'b0; cin[k] = 1'b0;
            a[k] = '0; b[k] = '0; out_ready[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || x[k] !== '0 ||
                cout[k] !== 1'b0 || ovf[k] !== 1'b0 || busy[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset/%0d got rdy=%b vld=%b x=%h cout=%b ovf=%b busy=%b want 1 0 0 0 0 0",
                         k, in_ready[k], out_valid[k], x[k], cout[k], ovf[k], busy[k]);
            end
            rst[k] = 1'b0;
        end
    endtask

    task automatic test_directed();
        for (int k = 0; k < 2; k++) begin
            run_op(k, 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, "add_carry");
            run_op(k, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, "sub_borrow");
            run_op(k, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, "sub_zero_cin");
            run_op(k, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "add_ovf");
            run_op(k, 1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 1'b0, "sub_ovf");
            run_op(k, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "add_wrap");
            run_op(k, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, "add_negovf");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            for (int k = 0; k < 2; k++) begin
                run_op(k, 1'($urandom_range(1)), 1'($urandom_range(1)),
                       $urandom, $urandom, 1'($urandom_range(1)), "random");
            end
        end
    endtask

    task automatic test_backpressure(input int k);
        logic [W-1:0] ex, ra, rb;
        logic         ec, ev;
        int           n;
        ra = $urandom; rb = $urandom;
        ref_model(1'b0, 1'b1, ra, rb, ex, ec, ev);
        @(negedge clk);
        in_valid[k] = 1'b1; op[k] = 1'b0; cin[k] = 1'b1; a[k] = ra; b[k] = rb;
        @(negedge clk);
        in_valid[k] = 1'b0;
        n = 0;
        while (out_valid[k] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int c = 0; c < 5; c++) begin
            in_valid[k] = 1'b1; op[k] = 1'b1; a[k] = $urandom; b[k] = $urandom;
            @(negedge clk);
            checks++;
            if (out_valid[k] !== 1'b1 || in_ready[k] !== 1'b0 || x[k] !== ex ||
                cout[k] !== ec || ovf[k] !== ev) begin
                errors++;
                $display("FAIL hold/%0d cyc %0d got vld=%b rdy=%b x=%h cout=%b ovf=%b want 1 0 %h %b %b",
                         k, c, out_valid[k], in_ready[k], x[k], cout[k], ovf[k], ex, ec, ev);
            end
        end
        in_valid[k] = 1'b0;
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL hold_release/%0d got busy=%b rdy=%b want 0 1", k, busy[k], in_ready[k]);
        end
    endtask

    task automatic test_reset_midrun(input int k);
        @(negedge clk);
        in_valid[k] = 1'b1; op[k] = 1'b0; cin[k] = 1'b0; a[k] = $urandom; b[k] = $urandom;
        @(negedge clk);
        in_valid[k] = 1'b0;
        repeat ((ndig_of(k) > 2) ? 2 : 1) @(negedge clk);
        checks++;
        if (busy[k] !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre/%0d busy got %b want 1", k, busy[k]);
        end
        rst[k] = 1'b1;
        #1;
        checks++;
        if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || x[k] !== '0 || busy[k] !== 1'b0) begin
            errors++;
            $display("FAIL abort/%0d got vld=%b rdy=%b x=%h busy=%b want 0 1 0 0",
                     k, out_valid[k], in_ready[k], x[k], busy[k]);
        end
        @(negedge clk);
        checks++;
        if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL abort_hold/%0d got vld=%b rdy=%b want 0 1", k, out_valid[k], in_ready[k]);
        end
        rst[k] = 1'b0;
        run_op(k, 1'b0, 1'b0, 32'd3, 32'd4, 1'b0, "after_abort");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure(0);
        test_backpressure(1);
        test_reset_midrun(0);
        test_reset_midrun(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
